// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (read-only) and load/store.
// One transaction in flight at a time; round-robin grant on contention.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1    // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_valid_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_ack_o,
    output logic [DATA_W-1:0] ls_data_o,
    output logic              ls_valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic       last_gnt;
    logic       cur_ls;
    logic       grant_if;
    logic       grant_ls;
    logic       rd_done;

    // last_gnt: 0 = IF, 1 = LS. On a tie the requester not served last wins.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !reset) begin
            if (if_req_i && ls_req_i) begin
                if (last_gnt) begin
                    grant_if = 1'b1;
                end else begin
                    grant_ls = 1'b1;
                end
            end else if (ls_req_i) begin
                grant_ls = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_ack_o = grant_if;
    assign ls_ack_o = grant_ls;
    assign rd_done  = (state == RD) && (cnt <= 3'd1);
    assign we_o     = (state == WR);
    assign busy_o   = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (grant_ls && ls_we_i) begin
                    state_next = WR;
                end else if (grant_ls || grant_if) begin
                    state_next = RD;
                    cnt_next   = LAT;
                end
            end
            RD: begin
                if (rd_done) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            WR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request capture at the ack edge; completion data and one-cycle valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt   <= 1'b0;
            cur_ls     <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            if_data_o  <= '0;
            ls_data_o  <= '0;
            if_valid_o <= 1'b0;
            ls_valid_o <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            ls_valid_o <= 1'b0;
            if (grant_ls) begin
                addr_o   <= ls_addr_i;
                last_gnt <= 1'b1;
                cur_ls   <= 1'b1;
                if (ls_we_i) begin
                    wdata_o <= ls_wdata_i;
                end
            end else if (grant_if) begin
                addr_o   <= if_addr_i;
                last_gnt <= 1'b0;
                cur_ls   <= 1'b0;
            end
            if (rd_done) begin
                if (cur_ls) begin
                    ls_data_o  <= data_i;
                    ls_valid_o <= 1'b1;
                end else begin
                    if_data_o  <= data_i;
                    if_valid_o <= 1'b1;
                end
            end
            if (state == WR) begin
                ls_valid_o <= 1'b1;
            end
        end
    end

endmodule
